// File: rtl/nios_system_mul_pkg.sv
// -----------------------------------------------------------------------------
// nios_system_mul_pkg
// Shared constants and types for the multiplier-sharing arbiter.
//   MUL_LATENCY : issue-to-result latency of the registered multiplier cell
//   MUL_W       : operand width
//   PROD_W      : product width
//   trk_entry_t : one slot of the in-flight ownership tracker {valid, id}
// -----------------------------------------------------------------------------
package nios_system_mul_pkg;

  localparam int MUL_LATENCY = 2;
  localparam int MUL_W       = 32;
  localparam int PROD_W      = 64;

  // Wide enough for the largest supported requester count (8).
  localparam int TRK_ID_W    = 3;

  typedef struct packed {
    logic                valid;
    logic [TRK_ID_W-1:0] id;
  } trk_entry_t;

endpackage

// File: rtl/nios_system_rr_arb.sv
// -----------------------------------------------------------------------------
// nios_system_rr_arb
// Combinational round-robin arbiter with a registered priority pointer.
// The search starts at the pointer; after a grant the pointer moves to the
// slot just past the winner, so every requester is reached within NUM_REQ
// grants.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (pointer -> 0)
//   req          : request vector
//   advance      : move the pointer past the current winner this cycle
//   grant        : one-hot grant (all zero when nothing requests)
//   grant_idx    : index of the winner (0 when nothing requests)
//   grant_any    : some requester won this cycle
// -----------------------------------------------------------------------------
module nios_system_rr_arb
  import nios_system_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_cand;

  // Scan NUM_REQ slots starting at the pointer; first requester found wins.
  // The sum is one bit wider so the wrap test works for non-power-of-two counts.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      end
      w_cand = w_sum[ID_W-1:0];
      if (!grant_any && req[w_cand]) begin
        grant_any = 1'b1;
        grant_idx = w_cand;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    if (grant_idx == ID_W'(NUM_REQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/nios_system_mul_arbiter.sv
// -----------------------------------------------------------------------------
// nios_system_mul_arbiter
// Shares one registered 32x32 multiplier cell (operand register + product
// register, two cycles issue to result) among NUM_REQ requesters. One
// operation is issued per cycle; the owner of each in-flight operation is
// carried alongside the cell's pipeline so the product returns tagged.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid/req_ready        : per-requester handshake, ready is one-hot
//   req_src1/req_src2          : packed operands, requester i at [32i+31:32i]
//   req_src1/2_signed          : per-operand signedness
//   mul_src1/2, mul_signa/b    : issue side of the multiplier cell
//   mul_clr                    : cell register clear, follows reset
//   mul_result                 : product from the cell
//   rsp_valid/rsp_id/rsp_result: tagged product, no backpressure
//   busy                       : an operation is in flight
// -----------------------------------------------------------------------------
module nios_system_mul_arbiter
  import nios_system_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*MUL_W-1:0] req_src1,
  input  logic [NUM_REQ*MUL_W-1:0] req_src2,
  input  logic [NUM_REQ-1:0]       req_src1_signed,
  input  logic [NUM_REQ-1:0]       req_src2_signed,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [MUL_W-1:0]         mul_src1,
  output logic [MUL_W-1:0]         mul_src2,
  output logic                     mul_signa,
  output logic                     mul_signb,
  output logic                     mul_clr,
  input  logic [PROD_W-1:0]        mul_result,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [PROD_W-1:0]        rsp_result,
  output logic                     busy
);

  logic [NUM_REQ-1:0] w_req_gated;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_grant_any;

  trk_entry_t r_trk_p0;
  trk_entry_t r_trk_p1;

  // Nothing may be granted while reset is high, so the cell never sees an
  // operand that the tracker would then forget.
  assign w_req_gated = req_valid & {NUM_REQ{~reset}};

  nios_system_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (w_req_gated),
    .advance   (w_grant_any),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  assign req_ready = w_grant;
  assign mul_clr   = reset;

  // ---- issue: operands muxed from the winner straight into the cell ----
  always_comb begin
    mul_src1  = '0;
    mul_src2  = '0;
    mul_signa = 1'b0;
    mul_signb = 1'b0;
    if (w_grant_any) begin
      mul_src1  = req_src1[w_grant_idx*MUL_W +: MUL_W];
      mul_src2  = req_src2[w_grant_idx*MUL_W +: MUL_W];
      mul_signa = req_src1_signed[w_grant_idx];
      mul_signb = req_src2_signed[w_grant_idx];
    end
  end

  // ---- p0: mirrors the cell's operand register ----
  // ---- p1: mirrors the cell's product register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_trk_p0 <= '0;
      r_trk_p1 <= '0;
    end else begin
      r_trk_p0.valid <= w_grant_any;
      r_trk_p0.id    <= TRK_ID_W'(w_grant_idx);
      r_trk_p1       <= r_trk_p0;
    end
  end

  // ---- response: product from the cell aligned with its owner ----
  assign rsp_valid  = r_trk_p1.valid;
  assign rsp_id     = ID_W'(r_trk_p1.id);
  assign rsp_result = mul_result;
  assign busy       = r_trk_p0.valid | r_trk_p1.valid;

endmodule

// File: tb/tb_nios_system_mul_arbiter.sv
module tb_nios_system_mul_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_src1;
  logic [N*32-1:0] req_src2;
  logic [N-1:0]    req_src1_signed;
  logic [N-1:0]    req_src2_signed;
  logic [N-1:0]    req_ready;
  logic [31:0]     mul_src1;
  logic [31:0]     mul_src2;
  logic            mul_signa;
  logic            mul_signb;
  logic            mul_clr;
  logic [63:0]     mul_result;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [63:0]     rsp_result;
  logic            busy;

  int n_assert = 0;
  int n_fail   = 0;

  int exp_lg [6] = '{1, 1, 1, 3, 1, 1};
  int exp_lr [6] = '{10, 11, 12, 50, 13, 14};
  int exp_fr [4] = '{300, 303, 306, 309};

  always #5 clk = ~clk;

  nios_system_mul_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_src1        (req_src1),
    .req_src2        (req_src2),
    .req_src1_signed (req_src1_signed),
    .req_src2_signed (req_src2_signed),
    .req_ready       (req_ready),
    .mul_src1        (mul_src1),
    .mul_src2        (mul_src2),
    .mul_signa       (mul_signa),
    .mul_signb       (mul_signb),
    .mul_clr         (mul_clr),
    .mul_result      (mul_result),
    .rsp_valid       (rsp_valid),
    .rsp_id          (rsp_id),
    .rsp_result      (rsp_result),
    .busy            (busy)
  );

  // Multiplier cell: operand registers, then product register, cleared by aclr.
  logic [31:0] c_a, c_b;
  logic        c_sa, c_sb;

  function automatic logic [63:0] cell_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb);
    logic signed [32:0] x;
    logic signed [32:0] y;
    logic signed [65:0] p;
    x = {sa & a[31], a};
    y = {sb & b[31], b};
    p = x * y;
    return p[63:0];
  endfunction

  always @(posedge clk) begin
    if (mul_clr) begin
      c_a <= '0; c_b <= '0; c_sa <= 1'b0; c_sb <= 1'b0; mul_result <= '0;
    end else begin
      c_a <= mul_src1; c_b <= mul_src2; c_sa <= mul_signa; c_sb <= mul_signb;
      mul_result <= cell_mul(c_a, c_b, c_sa, c_sb);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_src1 = '0;
    req_src2 = '0;
    req_src1_signed = '0;
    req_src2_signed = '0;
  endtask

  task automatic drive(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic sa, input logic sb);
    req_valid[i]          = v;
    req_src1[i*32 +: 32]  = a;
    req_src2[i*32 +: 32]  = b;
    req_src1_signed[i]    = sa;
    req_src2_signed[i]    = sb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n1;
    clear_all();
    reset = 1'b1;

    // Reset state with all requesters asking.
    @(negedge clk);
    for (int i = 0; i < N; i++) drive(i, 1'b1, 32'(i + 1), 32'(i + 2), 1'b1, 1'b1);
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_src1", 64'(mul_src1), 64'h0);
    chk("rst_src2", 64'(mul_src2), 64'h0);
    chk("rst_signa", 64'(mul_signa), 64'h0);
    chk("rst_clr", 64'(mul_clr), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_rspv", 64'(rsp_valid), 64'h0);

    @(negedge clk);
    reset = 1'b0;
    clear_all();
    #1;
    chk("post_rst_clr", 64'(mul_clr), 64'h0);
    chk("post_rst_rspv", 64'(rsp_valid), 64'h0);

    // Single op: 7 * 6 from requester 0.
    @(negedge clk);
    drive(0, 1'b1, 32'd7, 32'd6, 1'b0, 1'b0);
    #1;
    chk("single_ready", 64'(req_ready), 64'h1);
    chk("single_src1", 64'(mul_src1), 64'd7);
    chk("single_src2", 64'(mul_src2), 64'd6);
    chk("single_busy0", 64'(busy), 64'h0);
    @(negedge clk);
    clear_all();
    #1;
    chk("single_ready_off", 64'(req_ready), 64'h0);
    chk("single_rspv_t1", 64'(rsp_valid), 64'h0);
    chk("single_busy1", 64'(busy), 64'h1);
    chk("idle_src1", 64'(mul_src1), 64'h0);
    @(negedge clk);
    #1;
    chk("single_rspv_t2", 64'(rsp_valid), 64'h1);
    chk("single_id", 64'(rsp_id), 64'h0);
    chk("single_result", rsp_result, 64'd42);
    chk("single_busy2", 64'(busy), 64'h1);
    @(negedge clk);
    #1;
    chk("single_rspv_t3", 64'(rsp_valid), 64'h0);
    chk("single_busy3", 64'(busy), 64'h0);

    // Signedness, requester 2 back-to-back (pointer sits at 1).
    @(negedge clk);
    drive(2, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1);
    #1;
    chk("sgn_ready_ss", 64'(req_ready), 64'h4);
    chk("sgn_signa", 64'(mul_signa), 64'h1);
    chk("sgn_signb", 64'(mul_signb), 64'h1);
    @(negedge clk);
    drive(2, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    #1;
    chk("sgn_ready_uu", 64'(req_ready), 64'h4);
    chk("sgn_signa_u", 64'(mul_signa), 64'h0);
    @(negedge clk);
    drive(2, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    #1;
    chk("sgn_ready_min", 64'(req_ready), 64'h4);
    chk("sgn_rspv_ss", 64'(rsp_valid), 64'h1);
    chk("sgn_id_ss", 64'(rsp_id), 64'd2);
    chk("sgn_res_ss", rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    clear_all();
    #1;
    chk("sgn_rspv_uu", 64'(rsp_valid), 64'h1);
    chk("sgn_res_uu", rsp_result, 64'h0000_0001_FFFF_FFFE);
    @(negedge clk);
    #1;
    chk("sgn_rspv_min", 64'(rsp_valid), 64'h1);
    chk("sgn_res_min", rsp_result, 64'h4000_0000_0000_0000);
    @(negedge clk);
    #1;
    chk("sgn_rspv_end", 64'(rsp_valid), 64'h0);
    chk("sgn_busy_end", 64'(busy), 64'h0);

    // Short reset so the pointer restarts at 0.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Fairness: all four valid for 8 cycles, src1=100+i, src2=3.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) begin
        for (int i = 0; i < N; i++) drive(i, 1'b1, 32'(100 + i), 32'd3, 1'b0, 1'b0);
      end else begin
        clear_all();
      end
      #1;
      if (k < 8) chk($sformatf("fair_ready_%0d", k), 64'(req_ready), 64'(1) << (k % 4));
      else       chk($sformatf("fair_ready_%0d", k), 64'(req_ready), 64'h0);
      if (k >= 2) begin
        chk($sformatf("fair_rspv_%0d", k), 64'(rsp_valid), 64'h1);
        chk($sformatf("fair_id_%0d", k), 64'(rsp_id), 64'((k - 2) % 4));
        chk($sformatf("fair_res_%0d", k), rsp_result, 64'(exp_fr[(k - 2) % 4]));
      end else begin
        chk($sformatf("fair_rspv_%0d", k), 64'(rsp_valid), 64'h0);
      end
    end
    @(negedge clk);
    #1;
    chk("fair_drain_rspv", 64'(rsp_valid), 64'h0);
    chk("fair_drain_busy", 64'(busy), 64'h0);

    // Late arrival: req 1 bursts, req 3 appears at k=3.
    n1 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      clear_all();
      if (k < 6) drive(1, 1'b1, 32'(10 + n1), 32'd1, 1'b0, 1'b0);
      if (k == 3) drive(3, 1'b1, 32'd50, 32'd1, 1'b0, 1'b0);
      #1;
      if (k < 6) begin
        chk($sformatf("late_ready_%0d", k), 64'(req_ready), 64'(1) << exp_lg[k]);
        if (exp_lg[k] == 1) n1++;
      end else begin
        chk($sformatf("late_ready_%0d", k), 64'(req_ready), 64'h0);
      end
      if (k >= 2) begin
        chk($sformatf("late_rspv_%0d", k), 64'(rsp_valid), 64'h1);
        chk($sformatf("late_id_%0d", k), 64'(rsp_id), 64'(exp_lg[k - 2]));
        chk($sformatf("late_res_%0d", k), rsp_result, 64'(exp_lr[k - 2]));
      end
    end
    @(negedge clk);
    #1;
    chk("late_drain_rspv", 64'(rsp_valid), 64'h0);

    // Reset mid-flight (pointer at 2).
    @(negedge clk);
    clear_all();
    drive(2, 1'b1, 32'd5, 32'd5, 1'b0, 1'b0);
    #1;
    chk("rmf_ready_a", 64'(req_ready), 64'h4);
    @(negedge clk);
    clear_all();
    drive(0, 1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
    #1;
    chk("rmf_ready_b", 64'(req_ready), 64'h1);
    @(negedge clk);
    clear_all();
    drive(1, 1'b1, 32'd8, 32'd8, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rmf_ready_forced", 64'(req_ready), 64'h0);
    chk("rmf_clr", 64'(mul_clr), 64'h1);
    chk("rmf_src1", 64'(mul_src1), 64'h0);
    @(negedge clk);
    #1;
    chk("rmf_rspv_in_rst", 64'(rsp_valid), 64'h0);
    chk("rmf_busy_in_rst", 64'(busy), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    clear_all();
    #1;
    chk("rmf_rspv_after", 64'(rsp_valid), 64'h0);
    chk("rmf_busy_after", 64'(busy), 64'h0);
    @(negedge clk);
    for (int i = 0; i < N; i++) drive(i, 1'b1, 32'(3 + i), 32'd4, 1'b0, 1'b0);
    #1;
    chk("rmf_ptr_zero", 64'(req_ready), 64'h1);
    @(negedge clk);
    clear_all();
    #1;
    chk("rmf_rspv_t1", 64'(rsp_valid), 64'h0);
    chk("rmf_busy_t1", 64'(busy), 64'h1);
    @(negedge clk);
    #1;
    chk("rmf_rspv_t2", 64'(rsp_valid), 64'h1);
    chk("rmf_id", 64'(rsp_id), 64'h0);
    chk("rmf_result", rsp_result, 64'd12);
    @(negedge clk);
    #1;
    chk("rmf_rspv_t3", 64'(rsp_valid), 64'h0);
    chk("rmf_busy_t3", 64'(busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
